// File: rtl/ethernet_tx.sv
// ethernet_tx: nibble-wide Ethernet II frame transmitter.
// Emits preamble/SFD, MAC header and EtherType, forwards an upstream payload,
// zero-pads short payloads to the 46-byte minimum, optionally appends the FCS,
// then holds an inter-frame gap before accepting the next request.
// Optional feature: define ETH_FCS_EN to generate and append the CRC-32 FCS.
// Without it there is no FCS state and axi_last marks the final payload/pad nibble.
module ethernet_tx #(
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
  parameter int          IFG_NIBBLES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [47:0] dst_mac_in,
  input  logic [47:0] src_mac_in,
  output logic        ip_start,
  input  logic        ip_axiiv,
  input  logic [3:0]  ip_axiid,
  input  logic        ip_axi_last,
  output logic        ready,
  output logic        axiov,
  output logic [3:0]  axiod,
  output logic        axi_last
);

  // Frame layout in nibble indices (index 0 = first preamble nibble)
  localparam logic [5:0]  PRE_LAST   = 6'd15;   // last preamble/SFD nibble
  localparam logic [5:0]  SFD_HI     = 6'd14;   // 0xD of the SFD
  localparam logic [5:0]  START_IDX  = 6'd42;   // ip_start pulse position
  localparam logic [5:0]  HDR_LAST   = 6'd43;   // last EtherType nibble
  localparam logic [11:0] PAY_LAST   = 12'd91;  // 92 nibbles = 46-byte minimum body
  localparam logic [11:0] PAY_MAX    = 12'd3000;
  localparam logic [15:0] IFG_DONE   = 16'(IFG_NIBBLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_PAD,
`ifdef ETH_FCS_EN
    S_FCS,
`endif
    S_IFG
  } state_t;

  state_t        r_state;
  logic [5:0]    r_cnt;       // index of the next preamble/header nibble
  logic [111:0]  r_hdr;       // dst, src, EtherType; shifted out MSB first
  logic [11:0]   r_pay_cnt;   // payload + pad nibbles emitted so far
  logic [15:0]   r_ifg_cnt;   // idle (axiov=0) cycles already shown in IFG
  logic          r_axiov;
  logic [3:0]    r_axiod;
  logic          r_axi_last;
  logic          r_ip_start;
  logic          r_ready;

  logic          w_accept;

  assign w_accept = (r_state == S_IDLE) && axiiv;

  assign axiov    = r_axiov;
  assign axiod    = r_axiod;
  assign axi_last = r_axi_last;
  assign ip_start = r_ip_start;
  assign ready    = r_ready;

`ifdef ETH_FCS_EN
  logic [31:0] r_crc;       // running reflected CRC-32 (not yet inverted)
  logic [3:0]  r_crc_hi;    // high nibble waiting for its low partner
  logic        r_crc_half;  // 1 when r_crc_hi holds a pending high nibble
  logic [2:0]  r_fcs_cnt;
  logic        w_feed_en;
  logic [3:0]  w_feed_nib;
  logic [31:0] w_fcs;
  logic [7:0]  w_fcs_byte;
  logic [3:0]  w_fcs_nib;

  // Byte-wise reflected CRC-32 update, bits consumed LSB first as on the wire
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    end
    return x;
  endfunction

  // Select the nibble being emitted this edge that belongs to the CRC coverage
  always_comb begin
    w_feed_en  = 1'b0;
    w_feed_nib = 4'h0;
    case (r_state)
      S_HEADER: begin
        w_feed_en  = 1'b1;
        w_feed_nib = r_hdr[111:108];
      end
      S_PAYLOAD: begin
        w_feed_en  = ip_axiiv && (r_pay_cnt != PAY_MAX);
        w_feed_nib = ip_axiid;
      end
      S_PAD: begin
        w_feed_en  = 1'b1;
        w_feed_nib = 4'h0;
      end
      default: begin
        w_feed_en  = 1'b0;
        w_feed_nib = 4'h0;
      end
    endcase
  end

  // Pick the FCS nibble: bytes LSB first, each byte high nibble first
  always_comb begin
    w_fcs = ~r_crc;
    case (r_fcs_cnt[2:1])
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      default: w_fcs_byte = w_fcs[31:24];
    endcase
    w_fcs_nib = r_fcs_cnt[0] ? w_fcs_byte[3:0] : w_fcs_byte[7:4];
  end

  // Accumulate the CRC one full byte at a time once both nibbles have been seen
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_crc      <= 32'hFFFF_FFFF;
      r_crc_hi   <= 4'h0;
      r_crc_half <= 1'b0;
    end else if (w_feed_en) begin
      if (r_crc_half) begin
        r_crc <= crc32_byte(r_crc, {r_crc_hi, w_feed_nib});
      end
      r_crc_hi   <= w_feed_nib;
      r_crc_half <= ~r_crc_half;
    end
  end
`endif

  // Frame sequencer; every output is registered and defaults to idle each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hdr      <= '0;
      r_pay_cnt  <= '0;
      r_ifg_cnt  <= '0;
      r_axiov    <= 1'b0;
      r_axiod    <= 4'h0;
      r_axi_last <= 1'b0;
      r_ip_start <= 1'b0;
      r_ready    <= 1'b1;
`ifdef ETH_FCS_EN
      r_fcs_cnt  <= '0;
`endif
    end else begin
      r_axiov    <= 1'b0;
      r_axiod    <= 4'h0;
      r_axi_last <= 1'b0;
      r_ip_start <= 1'b0;
      r_ready    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (axiiv) begin
            // First preamble nibble goes out on the accepting edge
            r_hdr     <= {dst_mac_in, src_mac_in, ETHERTYPE};
            r_cnt     <= 6'd1;
            r_pay_cnt <= '0;
            r_axiov   <= 1'b1;
            r_axiod   <= 4'h5;
            r_state   <= S_PREAMBLE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_PREAMBLE: begin
          r_axiov <= 1'b1;
          r_axiod <= (r_cnt == SFD_HI) ? 4'hD : 4'h5;
          r_cnt   <= r_cnt + 6'd1;
          if (r_cnt == PRE_LAST) r_state <= S_HEADER;
        end
        S_HEADER: begin
          r_axiov    <= 1'b1;
          r_axiod    <= r_hdr[111:108];
          r_hdr      <= {r_hdr[107:0], 4'h0};
          r_cnt      <= r_cnt + 6'd1;
          // Upstream answers one cycle after the pulse, landing its first nibble at index 44
          r_ip_start <= (r_cnt == START_IDX);
          if (r_cnt == HDR_LAST) r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (!ip_axiiv || (r_pay_cnt == PAY_MAX)) begin
            // Abort: this idle cycle already counts toward the gap
            r_state   <= S_IFG;
            r_ifg_cnt <= 16'd1;
          end else begin
            r_axiov   <= 1'b1;
            r_axiod   <= ip_axiid;
            r_pay_cnt <= r_pay_cnt + 12'd1;
            if (ip_axi_last) begin
              if (r_pay_cnt < PAY_LAST) begin
                r_state <= S_PAD;
              end else begin
`ifdef ETH_FCS_EN
                r_state   <= S_FCS;
                r_fcs_cnt <= '0;
`else
                r_axi_last <= 1'b1;
                r_state    <= S_IFG;
                r_ifg_cnt  <= '0;
`endif
              end
            end
          end
        end
        S_PAD: begin
          r_axiov   <= 1'b1;
          r_axiod   <= 4'h0;
          r_pay_cnt <= r_pay_cnt + 12'd1;
          if (r_pay_cnt == PAY_LAST) begin
`ifdef ETH_FCS_EN
            r_state   <= S_FCS;
            r_fcs_cnt <= '0;
`else
            r_axi_last <= 1'b1;
            r_state    <= S_IFG;
            r_ifg_cnt  <= '0;
`endif
          end
        end
`ifdef ETH_FCS_EN
        S_FCS: begin
          r_axiov   <= 1'b1;
          r_axiod   <= w_fcs_nib;
          r_fcs_cnt <= r_fcs_cnt + 3'd1;
          if (r_fcs_cnt == 3'd7) begin
            r_axi_last <= 1'b1;
            r_state    <= S_IFG;
            r_ifg_cnt  <= '0;
          end
        end
`endif
        S_IFG: begin
          // Leave once IFG_NIBBLES idle cycles have been shown
          if (r_ifg_cnt == IFG_DONE) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_tx.sv
// Testbench for ethernet_tx: random frames checked against a frame-level
// reference (preamble, header, payload, pad, CRC-32 FCS built from a table).
`timescale 1ns/1ps
module tb_ethernet_tx;

  localparam logic [15:0] ETYPE      = 16'h0800;
  localparam int          IFG        = 24;
  localparam int          PAY_MIN    = 92;
  localparam int          PAY_MAX    = 3000;
  localparam int          CYC_BUDGET = 5000;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [47:0] dst_mac_in;
  logic [47:0] src_mac_in;
  logic        ip_start;
  logic        ip_axiiv;
  logic [3:0]  ip_axiid;
  logic        ip_axi_last;
  logic        ready;
  logic        axiov;
  logic [3:0]  axiod;
  logic        axi_last;

  always #5 clk = ~clk;

  ethernet_tx #(.ETHERTYPE(ETYPE), .IFG_NIBBLES(IFG)) dut (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (axiiv),
    .dst_mac_in  (dst_mac_in),
    .src_mac_in  (src_mac_in),
    .ip_start    (ip_start),
    .ip_axiiv    (ip_axiiv),
    .ip_axiid    (ip_axiid),
    .ip_axi_last (ip_axi_last),
    .ready       (ready),
    .axiov       (axiov),
    .axiod       (axiod),
    .axi_last    (axi_last)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          frame_no = 0;
  logic [31:0] crc_tab [256];
  logic [3:0]  pay_q [$];
  logic [3:0]  exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic build_crc_tab();
    for (int b = 0; b < 256; b++) begin
      logic [31:0] t;
      t = 32'(b);
      for (int k = 0; k < 8; k++) t = t[0] ? ((t >> 1) ^ 32'hEDB8_8320) : (t >> 1);
      crc_tab[b] = t;
    end
  endtask

  // Whole expected frame as a nibble list
  task automatic build_expected(input logic [47:0] dst, input logic [47:0] src);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  byt;
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    exp_q.push_back(4'h5);
    for (int i = 0; i < 12; i++) exp_q.push_back(4'(dst >> (44 - 4 * i)));
    for (int i = 0; i < 12; i++) exp_q.push_back(4'(src >> (44 - 4 * i)));
    for (int i = 0; i < 4; i++)  exp_q.push_back(4'(ETYPE >> (12 - 4 * i)));
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    for (int i = pay_q.size(); i < PAY_MIN; i++) exp_q.push_back(4'h0);
`ifdef ETH_FCS_EN
    crc = 32'hFFFF_FFFF;
    for (int k = 16; k + 1 < exp_q.size(); k += 2) begin
      byt = {exp_q[k], exp_q[k + 1]};
      crc = (crc >> 8) ^ crc_tab[crc[7:0] ^ byt];
    end
    fcs = ~crc;
    for (int b = 0; b < 4; b++) begin
      byt = 8'(fcs >> (8 * b));
      exp_q.push_back(byt[7:4]);
      exp_q.push_back(byt[3:0]);
    end
`endif
  endtask

  // One frame request; called and returns at a falling edge with ready expected high
  task automatic run_frame(input logic [47:0] dst, input logic [47:0] src, input int n_pay,
                           input int drop_at, input int rst_at, input bit ifg_poke);
    int exp_len, cyc, vcnt, start_pos, start_cnt, last_pos, last_cnt, runs;
    int last_vcyc, ready_cyc, up_idx, n_up, end_cyc;
    bit prev_v, start_pend, ended, done_rst, timed_out, abort;
    pay_q.delete();
    for (int i = 0; i < n_pay; i++) pay_q.push_back(4'($urandom_range(0, 15)));
    build_expected(dst, src);
    abort   = (drop_at >= 0) || (n_pay > PAY_MAX);
    exp_len = (drop_at >= 0) ? 44 + drop_at : (n_pay > PAY_MAX) ? 44 + PAY_MAX : exp_q.size();
    n_up    = (drop_at >= 0) ? drop_at : n_pay;
    frame_no++;
    vcnt = 0; start_pos = -1; start_cnt = 0; last_pos = -1; last_cnt = 0; runs = 0;
    last_vcyc = -1; ready_cyc = -1; up_idx = -1; end_cyc = -1;
    prev_v = 0; start_pend = 0; ended = 0; done_rst = 0; timed_out = 0;

    check_val("ready_before_req", 32'(ready), 1);
    axiiv = 1'b1;
    dst_mac_in = dst;
    src_mac_in = src;
    @(negedge clk);
    axiiv = 1'b0;
    dst_mac_in = {16'($urandom), $urandom};
    src_mac_in = {16'($urandom), $urandom};
    check_val("first_nibble_latency", 32'(axiov), 1);
    cyc = 0;
    forever begin
      if (ip_start) begin
        start_cnt++;
        start_pos = axiov ? vcnt : -2;
      end
      if (axiov) begin
        if (vcnt < exp_q.size())
          check_val($sformatf("f%0d_nib%0d", frame_no, vcnt), 32'(axiod), 32'(exp_q[vcnt]));
        if (axi_last) begin
          last_cnt++;
          last_pos = vcnt;
        end
        if (!prev_v) runs++;
        vcnt++;
        last_vcyc = cyc;
      end
      if (prev_v && !axiov && !ended) begin
        ended   = 1;
        end_cyc = cyc;
      end
      prev_v = axiov;
      if (ready) begin
        ready_cyc = cyc;
        break;
      end
      if (rst_at >= 0 && vcnt == 44 + rst_at) begin
        rst = 1'b1;
        ip_axiiv = 1'b0;
        ip_axi_last = 1'b0;
        @(negedge clk);
        check_val("rst_axiov", 32'(axiov), 0);
        check_val("rst_axiod", 32'(axiod), 0);
        check_val("rst_axi_last", 32'(axi_last), 0);
        check_val("rst_ip_start", 32'(ip_start), 0);
        check_val("rst_ready", 32'(ready), 1);
        rst = 1'b0;
        done_rst = 1;
        break;
      end
      // Upstream source: first nibble one cycle after it sees ip_start
      if (start_pend) begin
        up_idx = 0;
        start_pend = 0;
      end
      if (up_idx >= 0 && up_idx < n_up) begin
        ip_axiiv    = 1'b1;
        ip_axiid    = pay_q[up_idx];
        ip_axi_last = (drop_at < 0) && (up_idx == n_pay - 1);
        up_idx++;
      end else if (up_idx == n_up && drop_at >= 0) begin
        ip_axiiv    = 1'b0;
        ip_axiid    = 4'h0;
        ip_axi_last = 1'b0;
        up_idx++;
      end else begin
        ip_axiiv    = 1'($urandom);
        ip_axiid    = 4'($urandom);
        ip_axi_last = 1'($urandom);
      end
      if (ip_start) start_pend = 1;
      axiiv = ifg_poke && ended && (cyc == end_cyc + 3);
      cyc++;
      if (cyc > CYC_BUDGET) begin
        check_val("ready_timeout", 32'(ready), 1);
        timed_out = 1;
        break;
      end
      @(negedge clk);
    end
    axiiv = 1'b0;

    if (!timed_out) begin
      check_val("valid_runs", runs, 1);
      check_val("ip_start_count", start_cnt, 1);
      check_val("ip_start_index", start_pos, 42);
      check_val("axi_last_count", last_cnt, (abort || done_rst) ? 0 : 1);
      if (!done_rst) begin
        check_val("valid_count", vcnt, exp_len);
        check_val("axi_last_index", last_pos, abort ? -1 : exp_len - 1);
        check_val("ifg_gap", ready_cyc - last_vcyc, IFG + 1);
      end
    end
    $display("frame %0d: payload=%0d drop=%0d rst_at=%0d valid=%0d expected=%0d last_at=%0d",
             frame_no, n_pay, drop_at, rst_at, vcnt, exp_len, last_pos);
  endtask

  initial begin
    int n;
    int drop;
    build_crc_tab();
    rst = 1'b1;
    axiiv = 1'b0;
    dst_mac_in = '0;
    src_mac_in = '0;
    ip_axiiv = 1'b0;
    ip_axiid = 4'h0;
    ip_axi_last = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_axiov", 32'(axiov), 0);
    check_val("reset_axiod", 32'(axiod), 0);
    check_val("reset_axi_last", 32'(axi_last), 0);
    check_val("reset_ip_start", 32'(ip_start), 0);
    check_val("reset_ready", 32'(ready), 1);
    rst = 1'b0;
    @(negedge clk);

    run_frame(48'hFFFF_FFFF_FFFF, 48'h6969_6969_6969, 40, -1, -1, 1'b0);
    run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 200, -1, -1, 1'b1);
    run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 40, 10, -1, 1'b1);
    run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 60, -1, 20, 1'b0);
    run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 92, -1, -1, 1'b0);
    run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 91, -1, -1, 1'b0);
    run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 1, -1, -1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      n = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 91) : 2 * $urandom_range(46, 200);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, n, drop, -1,
                1'($urandom_range(0, 1)));
    end
    run_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, PAY_MAX + 100, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
